// File: rtl/wb_chk_pkg.sv
// Shared types for the writeback scoreboard.
//   wb_state_e  : checker FSM encoding (IDLE=0, RUN=1, PASS=2, FAIL=3)
//   exp_entry_t : one expected writeback (pc, rd, data) at the default 64-bit XLEN
//   abi_name    : RISC-V ABI mnemonic for a register index, 4 chars right-aligned
package wb_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } wb_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_entry_t;

    function automatic logic [31:0] abi_name(input logic [4:0] r);
        logic [31:0] n;
        case (r)
            5'd0:  n = "zero";
            5'd1:  n = "  ra";
            5'd2:  n = "  sp";
            5'd3:  n = "  gp";
            5'd4:  n = "  tp";
            5'd5:  n = "  t0";
            5'd6:  n = "  t1";
            5'd7:  n = "  t2";
            5'd8:  n = "  s0";
            5'd9:  n = "  s1";
            5'd10: n = "  a0";
            5'd11: n = "  a1";
            5'd12: n = "  a2";
            5'd13: n = "  a3";
            5'd14: n = "  a4";
            5'd15: n = "  a5";
            5'd16: n = "  a6";
            5'd17: n = "  a7";
            5'd18: n = "  s2";
            5'd19: n = "  s3";
            5'd20: n = "  s4";
            5'd21: n = "  s5";
            5'd22: n = "  s6";
            5'd23: n = "  s7";
            5'd24: n = "  s8";
            5'd25: n = "  s9";
            5'd26: n = " s10";
            5'd27: n = " s11";
            5'd28: n = "  t3";
            5'd29: n = "  t4";
            5'd30: n = "  t5";
            default: n = "  t6";
        endcase
        return n;
    endfunction

endpackage

// File: rtl/wb_exp_fifo.sv
// Expectation FIFO: one push per cycle, 0..NCH pops per cycle.
//   push/push_data : write one entry (caller guarantees space)
//   pop_cnt        : entries to retire this cycle (caller guarantees <= count)
//   peek           : entries head..head+NCH-1, slot i in slice i
//   count          : current occupancy
module wb_exp_fifo
    import wb_chk_pkg::*;
#(
    parameter int unsigned NCH   = 2,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 133
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic [$clog2(NCH+1)-1:0]     pop_cnt,
    output logic [NCH*W-1:0]             peek,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            head  <= head + AW'(pop_cnt);
            count <= count + OW'(push) - OW'(pop_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

    // Pointer arithmetic is AW bits wide so peek slots wrap modulo DEPTH.
    always_comb begin
        peek = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            peek[i*W +: W] = mem[head + AW'(i)];
        end
    end

endmodule

// File: rtl/wb_checker.sv
// Writeback scoreboard: compares retired register writes against a queue of
// expected (pc, rd, data) triples and produces a PASS/FAIL verdict.
//   exp_*        : expectation push handshake and payload
//   start        : IDLE -> RUN
//   end_of_test  : take verdict in RUN
//   wb_*         : NCH retire channels, channel i in slice i
//   state        : IDLE/RUN/PASS/FAIL; done/pass reflect the verdict
//   match_cnt, mismatch_cnt : saturating counters
//   err_*        : actual values of the first mismatching retire
module wb_checker
    import wb_chk_pkg::*;
#(
    parameter int unsigned NCH     = 2,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNTW    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 exp_valid,
    output logic                 exp_ready,
    input  logic [XLEN-1:0]      exp_pc,
    input  logic [4:0]           exp_rd,
    input  logic [XLEN-1:0]      exp_data,
    input  logic                 start,
    input  logic                 end_of_test,
    input  logic [NCH-1:0]       wb_valid,
    input  logic [NCH*XLEN-1:0]  wb_pc,
    input  logic [NCH*5-1:0]     wb_rd,
    input  logic [NCH*XLEN-1:0]  wb_data,
    output logic [1:0]           state,
    output logic                 done,
    output logic                 pass,
    output logic [CNTW-1:0]      match_cnt,
    output logic [CNTW-1:0]      mismatch_cnt,
    output logic                 err_valid,
    output logic [XLEN-1:0]      err_pc,
    output logic [4:0]           err_rd,
    output logic [XLEN-1:0]      err_data
);

    localparam int unsigned W  = 2*XLEN + 5;
    localparam int unsigned CW = $clog2(NCH+1);
    localparam int unsigned OW = $clog2(DEPTH+1);
    localparam int unsigned TW = $clog2(TIMEOUT+1);
    localparam logic [OW-1:0] DEPTH_V = OW'(DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT-1);

    wb_state_e         state_q, state_d;
    logic [OW-1:0]     occ;
    logic [NCH*W-1:0]  peek;
    logic              push;
    logic [CW-1:0]     n_pop, n_match, n_mis;
    logic [W-1:0]      act, first_bad;
    logic              any_ret;
    int unsigned       k;
    logic [TW-1:0]     to_cnt;
    logic              to_inc;
    logic [OW:0]       occ_after;
    logic              verdict_pass;
    logic [CNTW:0]     match_sum, mis_sum;

    assign push = exp_valid && exp_ready;

    wb_exp_fifo #(
        .NCH   (NCH),
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({exp_pc, exp_rd, exp_data}),
        .pop_cnt   (n_pop),
        .peek      (peek),
        .count     (occ)
    );

    // Valid retires are compacted in channel order: the k-th valid retire
    // compares against FIFO slot k; slots past the occupancy are unexpected.
    always_comb begin
        n_pop     = '0;
        n_match   = '0;
        n_mis     = '0;
        first_bad = '0;
        act       = '0;
        any_ret   = 1'b0;
        k         = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            act = {wb_pc[i*XLEN +: XLEN], wb_rd[i*5 +: 5], wb_data[i*XLEN +: XLEN]};
            if (state_q == ST_RUN && wb_valid[i] && wb_rd[i*5 +: 5] != 5'd0) begin
                any_ret = 1'b1;
                if (k < 32'(occ) && act == peek[k*W +: W]) begin
                    n_match = n_match + 1'b1;
                end else begin
                    if (n_mis == '0) begin
                        first_bad = act;
                    end
                    n_mis = n_mis + 1'b1;
                end
                if (k < 32'(occ)) begin
                    n_pop = n_pop + 1'b1;
                end
                k = k + 1;
            end
        end
    end

    assign match_sum    = {1'b0, match_cnt}    + (CNTW+1)'(n_match);
    assign mis_sum      = {1'b0, mismatch_cnt} + (CNTW+1)'(n_mis);
    assign occ_after    = {1'b0, occ} + (OW+1)'(push) - (OW+1)'(n_pop);
    assign verdict_pass = (mismatch_cnt == '0) && (n_mis == '0) && (occ_after == '0);
    assign to_inc       = (state_q == ST_RUN) && !any_ret && (occ != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (end_of_test) begin
                    state_d = verdict_pass ? ST_PASS : ST_FAIL;
                end else if (to_inc && to_cnt == TO_LAST) begin
                    state_d = ST_FAIL;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        done      = (state_q == ST_PASS) || (state_q == ST_FAIL);
        pass      = (state_q == ST_PASS);
        exp_ready = (occ < DEPTH_V) && ((state_q == ST_IDLE) || (state_q == ST_RUN));
        state     = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            err_valid    <= 1'b0;
            err_pc       <= '0;
            err_rd       <= '0;
            err_data     <= '0;
            to_cnt       <= '0;
        end else begin
            match_cnt    <= match_sum[CNTW] ? '1 : match_sum[CNTW-1:0];
            mismatch_cnt <= mis_sum[CNTW]   ? '1 : mis_sum[CNTW-1:0];
            if (!err_valid && n_mis != '0) begin
                err_valid                  <= 1'b1;
                {err_pc, err_rd, err_data} <= first_bad;
            end
            to_cnt <= to_inc ? to_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_wb_checker.sv
// Directed bench for wb_checker (NCH=2, DEPTH=16, XLEN=64, TIMEOUT=8).
module tb_wb_checker;
    import wb_chk_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         exp_valid;
    logic         exp_ready;
    logic [63:0]  exp_pc;
    logic [4:0]   exp_rd;
    logic [63:0]  exp_data;
    logic         start;
    logic         end_of_test;
    logic [1:0]   wb_valid;
    logic [127:0] wb_pc;
    logic [9:0]   wb_rd;
    logic [127:0] wb_data;
    logic [1:0]   state;
    logic         done;
    logic         pass;
    logic [15:0]  match_cnt;
    logic [15:0]  mismatch_cnt;
    logic         err_valid;
    logic [63:0]  err_pc;
    logic [4:0]   err_rd;
    logic [63:0]  err_data;

    int checks = 0;
    int errors = 0;

    wb_checker #(
        .NCH     (2),
        .DEPTH   (16),
        .XLEN    (64),
        .TIMEOUT (8),
        .CNTW    (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exp_valid    (exp_valid),
        .exp_ready    (exp_ready),
        .exp_pc       (exp_pc),
        .exp_rd       (exp_rd),
        .exp_data     (exp_data),
        .start        (start),
        .end_of_test  (end_of_test),
        .wb_valid     (wb_valid),
        .wb_pc        (wb_pc),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .state        (state),
        .done         (done),
        .pass         (pass),
        .match_cnt    (match_cnt),
        .mismatch_cnt (mismatch_cnt),
        .err_valid    (err_valid),
        .err_pc       (err_pc),
        .err_rd       (err_rd),
        .err_data     (err_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_wb();
        wb_valid = '0;
        wb_pc    = '0;
        wb_rd    = '0;
        wb_data  = '0;
    endtask

    task automatic clr_all();
        clr_wb();
        exp_valid   = 1'b0;
        exp_pc      = '0;
        exp_rd      = '0;
        exp_data    = '0;
        start       = 1'b0;
        end_of_test = 1'b0;
    endtask

    task automatic do_reset();
        clr_all();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic set_ch(input int ch, input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] d);
        wb_valid[ch]        = 1'b1;
        wb_pc[ch*64 +: 64]  = pc;
        wb_rd[ch*5 +: 5]    = rd;
        wb_data[ch*64 +: 64] = d;
    endtask

    task automatic drive_exp(input exp_entry_t e);
        exp_valid = 1'b1;
        exp_pc    = e.pc;
        exp_rd    = e.rd;
        exp_data  = e.data;
    endtask

    task automatic do_push(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] d);
        exp_entry_t e;
        e = '{pc: pc, rd: rd, data: d};
        drive_exp(e);
        step();
        exp_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_eot();
        end_of_test = 1'b1;
        step();
        end_of_test = 1'b0;
    endtask

    function automatic exp_entry_t ent(input int i);
        exp_entry_t e;
        e.pc   = 64'h2000 + 64'(4 * i);
        e.rd   = 5'((i % 31) + 1);
        e.data = 64'h0a0a_0000 + 64'(3 * i);
        return e;
    endfunction

    task automatic test_reset();
        logic [31:0] nm;
        clr_all();
        rst_n = 1'b0;
        #3;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        rst_n = 1'b1;
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %0b exp 0", pass); end
        checks++; if (match_cnt !== 16'd0) begin errors++; $display("FAIL reset_match got %0d exp 0", match_cnt); end
        checks++; if (mismatch_cnt !== 16'd0) begin errors++; $display("FAIL reset_mis got %0d exp 0", mismatch_cnt); end
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL reset_errv got %0b exp 0", err_valid); end
        checks++; if (err_data !== 64'd0) begin errors++; $display("FAIL reset_errdata got %0h exp 0", err_data); end
        checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", exp_ready); end
        nm = abi_name(5'd10);
        checks++; if (nm !== "  a0") begin errors++; $display("FAIL abi_name got %s exp a0", nm); end
    endtask

    task automatic test_basic_match();
        do_reset();
        do_push(64'h1004, 5'd7, 64'd8);
        do_start();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL basic_run got %0d exp 1", state); end
        set_ch(0, 64'h1004, 5'd7, 64'd8);
        step();
        clr_wb();
        checks++; if (match_cnt !== 16'd1) begin errors++; $display("FAIL basic_match got %0d exp 1", match_cnt); end
        checks++; if (mismatch_cnt !== 16'd0) begin errors++; $display("FAIL basic_mis got %0d exp 0", mismatch_cnt); end
        do_eot();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL basic_state got %0d exp 2", state); end
        checks++; if (pass !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL basic_verdict got pass=%0b done=%0b exp 1 1", pass, done); end
    endtask

    task automatic test_two_channel();
        do_reset();
        do_push(64'h1000, 5'd5, 64'd1);
        do_push(64'h1004, 5'd6, 64'd2);
        do_start();
        set_ch(0, 64'h1000, 5'd5, 64'd1);
        set_ch(1, 64'h1004, 5'd6, 64'd2);
        step();
        clr_wb();
        checks++; if (match_cnt !== 16'd2) begin errors++; $display("FAIL dual_match got %0d exp 2", match_cnt); end
        checks++; if (mismatch_cnt !== 16'd0) begin errors++; $display("FAIL dual_mis got %0d exp 0", mismatch_cnt); end
        do_push(64'h1008, 5'd8, 64'd3);
        // ch0 carries a junk payload with its strobe low; ch1 must compact to slot 0.
        wb_pc[63:0]   = 64'hdead;
        wb_rd[4:0]    = 5'd9;
        wb_data[63:0] = 64'hbeef;
        set_ch(1, 64'h1008, 5'd8, 64'd3);
        end_of_test = 1'b1;
        step();
        end_of_test = 1'b0;
        clr_wb();
        checks++; if (match_cnt !== 16'd3) begin errors++; $display("FAIL compact_match got %0d exp 3", match_cnt); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL same_cycle_eot_state got %0d exp 2", state); end
    endtask

    task automatic test_mismatch();
        do_reset();
        do_push(64'h100c, 5'd7, 64'd2);
        do_start();
        set_ch(0, 64'h100c, 5'd7, 64'd3);
        step();
        clr_wb();
        checks++; if (mismatch_cnt !== 16'd1) begin errors++; $display("FAIL mis_cnt got %0d exp 1", mismatch_cnt); end
        checks++; if (match_cnt !== 16'd0) begin errors++; $display("FAIL mis_match got %0d exp 0", match_cnt); end
        checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL mis_errv got %0b exp 1", err_valid); end
        checks++; if (err_data !== 64'd3) begin errors++; $display("FAIL mis_errdata got %0h exp 3", err_data); end
        checks++; if (err_pc !== 64'h100c || err_rd !== 5'd7) begin errors++; $display("FAIL mis_errpc got %0h/%0d exp 100c/7", err_pc, err_rd); end
        set_ch(1, 64'h2000, 5'd9, 64'd5);
        step();
        clr_wb();
        checks++; if (mismatch_cnt !== 16'd2) begin errors++; $display("FAIL unexpected_cnt got %0d exp 2", mismatch_cnt); end
        checks++; if (err_data !== 64'd3 || err_rd !== 5'd7) begin errors++; $display("FAIL err_held got %0h/%0d exp 3/7", err_data, err_rd); end
        do_eot();
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL mis_state got %0d exp 3", state); end
        checks++; if (pass !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL mis_verdict got pass=%0b done=%0b exp 0 1", pass, done); end
        checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL fail_ready got %0b exp 0", exp_ready); end
        set_ch(0, 64'h3000, 5'd3, 64'd1);
        step();
        clr_wb();
        checks++; if (mismatch_cnt !== 16'd2) begin errors++; $display("FAIL post_verdict_cnt got %0d exp 2", mismatch_cnt); end
    endtask

    task automatic test_x0();
        do_reset();
        set_ch(0, 64'h3000, 5'd3, 64'd1);
        step();
        clr_wb();
        checks++; if (mismatch_cnt !== 16'd0 || match_cnt !== 16'd0) begin errors++; $display("FAIL idle_retire got %0d/%0d exp 0/0", match_cnt, mismatch_cnt); end
        do_start();
        set_ch(0, 64'h3004, 5'd0, 64'hdead);
        set_ch(1, 64'h3008, 5'd0, 64'hbeef);
        step();
        clr_wb();
        checks++; if (mismatch_cnt !== 16'd0 || match_cnt !== 16'd0) begin errors++; $display("FAIL x0_cnt got %0d/%0d exp 0/0", match_cnt, mismatch_cnt); end
        do_eot();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL x0_state got %0d exp 2", state); end
    endtask

    task automatic test_full_wrap();
        int next_push;
        int next_ret;
        int r;
        bit pushed;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_exp(ent(i));
            step();
        end
        exp_valid = 1'b0;
        checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", exp_ready); end
        drive_exp(ent(16));
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %0b exp 0", exp_ready); end
        set_ch(0, ent(0).pc, ent(0).rd, ent(0).data);
        step();
        clr_wb();
        checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL freed_ready got %0b exp 1", exp_ready); end
        step();
        exp_valid = 1'b0;
        checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL accepted_ready got %0b exp 0", exp_ready); end
        next_push = 17;
        next_ret  = 1;
        for (int it = 0; it < 100 && next_ret < 40; it++) begin
            clr_wb();
            pushed = 1'b0;
            exp_valid = 1'b0;
            if (next_push < 40 && exp_ready) begin
                drive_exp(ent(next_push));
                pushed = 1'b1;
            end
            r = next_push - next_ret;
            if (r > 2) r = 2;
            for (int j = 0; j < r; j++) begin
                set_ch(j, ent(next_ret + j).pc, ent(next_ret + j).rd, ent(next_ret + j).data);
            end
            step();
            next_ret += r;
            if (pushed) next_push++;
        end
        exp_valid = 1'b0;
        clr_wb();
        checks++; if (next_ret !== 40) begin errors++; $display("FAIL wrap_progress got %0d exp 40", next_ret); end
        checks++; if (match_cnt !== 16'd40) begin errors++; $display("FAIL wrap_match got %0d exp 40", match_cnt); end
        checks++; if (mismatch_cnt !== 16'd0) begin errors++; $display("FAIL wrap_mis got %0d exp 0", mismatch_cnt); end
        do_eot();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL wrap_state got %0d exp 2", state); end
    endtask

    task automatic test_timeout();
        do_reset();
        do_push(64'h4000, 5'd4, 64'd4);
        do_start();
        for (int c = 1; c <= 7; c++) step();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL timeout_early got %0d exp 1", state); end
        step();
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL timeout_state got %0d exp 3", state); end
        checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL timeout_verdict got done=%0b pass=%0b exp 1 0", done, pass); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        do_push(64'h5000, 5'd5, 64'd5);
        do_push(64'h5004, 5'd6, 64'd6);
        do_start();
        set_ch(0, 64'h5000, 5'd5, 64'd9);
        step();
        clr_wb();
        checks++; if (mismatch_cnt !== 16'd1) begin errors++; $display("FAIL midrun_pre got %0d exp 1", mismatch_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL midrun_state got %0d exp 0", state); end
        checks++; if (mismatch_cnt !== 16'd0 || match_cnt !== 16'd0) begin errors++; $display("FAIL midrun_cnt got %0d/%0d exp 0/0", match_cnt, mismatch_cnt); end
        checks++; if (err_valid !== 1'b0 || err_data !== 64'd0) begin errors++; $display("FAIL midrun_err got %0b/%0h exp 0/0", err_valid, err_data); end
        checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL midrun_ready got %0b exp 1", exp_ready); end
        step();
        rst_n = 1'b1;
        do_start();
        do_eot();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL midrun_fifo_cleared got %0d exp 2", state); end
    endtask

    initial begin
        test_reset();
        test_basic_match();
        test_two_channel();
        test_mismatch();
        test_x0();
        test_full_wrap();
        test_timeout();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
